// File: rtl/eq_band_sched.sv
`default_nettype none
// ============================================================================
// eq_band_sched : round-robin owner of the shared coefficient-ROM MAC engine
//                 for the equalizer band filters; captures saturated Q1.15.
// Revision     : 1.0
// ============================================================================
module eq_band_sched #(
   parameter int NBANDS = 5,
   parameter int TAPS   = 1021,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NBANDS-1:0] req,
   input  logic [31:0]       acc_rght,
   input  logic [31:0]       acc_lft,
   output logic [AW-1:0]     coef_addr,
   output logic [2:0]        band_sel,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              busy,
   output logic [15:0]       out_rght,
   output logic [15:0]       out_lft,
   output logic [2:0]        out_band,
   output logic              out_vld,
   output logic [NBANDS-1:0] ovr
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      CAPT  = 3'd4
   } state_t;

   state_t            state;
   logic [NBANDS-1:0] pending;
   logic [2:0]        last;

   logic [7:0]        pend8;
   logic [3:0]        cand;
   logic              grant_vld;
   logic [2:0]        grant_idx;
   logic [NBANDS-1:0] grant_clr;

   logic [15:0]       sat_rght;
   logic [15:0]       sat_lft;
   logic              unused_lsbs;

   assign pend8 = 8'(pending);

   // Search upward from last+1, wrapping; cand never exceeds 2*NBANDS-1,
   // so a single conditional subtract implements the modulo.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = last;
      cand      = 4'd0;
      for (int k = 1; k <= NBANDS; k++) begin
         cand = {1'b0, last} + 4'(k);
         if (cand >= 4'(NBANDS))
            cand = cand - 4'(NBANDS);
         if (!grant_vld && pend8[cand[2:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[2:0];
         end
      end
   end

   assign grant_clr = (state == IDLE && grant_vld) ? (NBANDS'(1) << grant_idx) : '0;

   // Bits 31 and 30 agreeing means a[30:15] already holds the Q1.15 value.
   assign sat_rght = (acc_rght[31] == acc_rght[30]) ? acc_rght[30:15]
                   : (acc_rght[31] ? 16'h8000 : 16'h7FFF);
   assign sat_lft  = (acc_lft[31] == acc_lft[30]) ? acc_lft[30:15]
                   : (acc_lft[31] ? 16'h8000 : 16'h7FFF);
   assign unused_lsbs = ^{acc_rght[14:0], acc_lft[14:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pending   <= '0;
         ovr       <= '0;
         last      <= 3'(NBANDS - 1);
         coef_addr <= '0;
         band_sel  <= 3'd0;
         acc_clr   <= 1'b0;
         acc_en    <= 1'b0;
         busy      <= 1'b0;
         out_rght  <= 16'd0;
         out_lft   <= 16'd0;
         out_band  <= 3'd0;
         out_vld   <= 1'b0;
      end else begin
         // A request landing on the grant of its own band survives as new work.
         pending <= (pending & ~grant_clr) | req;
         ovr     <= ovr | (req & pending & ~grant_clr);
         acc_en  <= (state == RUN);
         acc_clr <= 1'b0;
         out_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  band_sel  <= grant_idx;
                  last      <= grant_idx;
                  acc_clr   <= 1'b1;
                  coef_addr <= '0;
                  busy      <= 1'b1;
                  state     <= CLR;
               end
            end
            CLR: begin
               coef_addr <= '0;
               state     <= RUN;
            end
            RUN: begin
               if (coef_addr == AW'(TAPS - 1)) begin
                  coef_addr <= '0;
                  state     <= DRAIN;
               end else begin
                  coef_addr <= coef_addr + 1'b1;
               end
            end
            DRAIN: begin
               state <= CAPT;
            end
            CAPT: begin
               out_rght <= sat_rght;
               out_lft  <= sat_lft;
               out_band <= band_sel;
               out_vld  <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eq_band_sched.sv
`default_nettype none
// ============================================================================
// tb_eq_band_sched : self-checking bench for eq_band_sched (TAPS=4, NBANDS=5)
// Revision         : 1.0
// ============================================================================
module tb_eq_band_sched;
   localparam int NB  = 5;
   localparam int TP  = 4;
   localparam int AWB = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic [NB-1:0]  req;
   logic [31:0]    acc_rght, acc_lft;
   logic [AWB-1:0] coef_addr;
   logic [2:0]     band_sel, out_band;
   logic           acc_clr, acc_en, busy, out_vld;
   logic [15:0]    out_rght, out_lft;
   logic [NB-1:0]  ovr;

   eq_band_sched #(.NBANDS(NB), .TAPS(TP), .AW(AWB)) dut (
      .clk(clk), .rst(rst), .req(req), .acc_rght(acc_rght), .acc_lft(acc_lft),
      .coef_addr(coef_addr), .band_sel(band_sel), .acc_clr(acc_clr), .acc_en(acc_en),
      .busy(busy), .out_rght(out_rght), .out_lft(out_lft), .out_band(out_band),
      .out_vld(out_vld), .ovr(ovr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   logic [31:0] hold_r = 32'd0;
   logic [31:0] hold_l = 32'd0;

   typedef struct { int cyc; int band; logic [15:0] r; logic [15:0] l; } res_t;
   res_t vlog[$];

   // Transaction-level reference: pending set, last winner, and the offset
   // into the current service (1 = clear cycle ... TP+3 = capture cycle).
   bit [NB-1:0] m_pend, m_ovr;
   int          m_last, m_d, m_band, m_ob;
   bit          m_active, m_vld;
   logic [15:0] m_or, m_ol;

   function automatic logic [15:0] sat16(input logic [31:0] a);
      longint v;
      logic [63:0] bits;
      v = longint'($signed(a));
      v = v >>> 15;
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      bits = 64'(v);
      return bits[15:0];
   endfunction

   task automatic model_reset();
      m_pend = '0; m_ovr = '0; m_last = NB - 1; m_d = 0; m_band = 0; m_ob = 0;
      m_active = 0; m_vld = 0; m_or = 16'd0; m_ol = 16'd0;
   endtask

   task automatic model_step(input logic [NB-1:0] r, input logic [31:0] ar, input logic [31:0] al);
      bit [NB-1:0] clr_mask;
      bit          nv;
      int          pick;
      clr_mask = '0;
      pick     = -1;
      nv       = m_active && (m_d == TP + 3);
      if (nv) begin
         m_or = sat16(ar); m_ol = sat16(al); m_ob = m_band;
      end
      if (!m_active && m_pend != '0) begin
         for (int k = 1; k <= NB; k++)
            if (pick < 0 && m_pend[(m_last + k) % NB]) pick = (m_last + k) % NB;
         clr_mask[pick] = 1'b1;
         m_band = pick; m_last = pick; m_active = 1; m_d = 1;
      end else if (m_active) begin
         if (m_d == TP + 3) m_active = 0;
         else m_d++;
      end
      m_ovr  = m_ovr | (r & m_pend & ~clr_mask);
      m_pend = (m_pend & ~clr_mask) | r;
      m_vld  = nv;
   endtask

   // One clock: drive inputs mid-cycle, advance the model, log any result.
   task automatic cycle(input logic [NB-1:0] r, input logic [31:0] ar, input logic [31:0] al);
      req = r; acc_rght = ar; acc_lft = al;
      model_step(r, ar, al);
      @(negedge clk);
      cyc++;
      if (out_vld) vlog.push_back('{cyc, int'(out_band), out_rght, out_lft});
   endtask

   task automatic run_until(input int n, input int budget);
      for (int i = 0; i < budget && vlog.size() < n; i++) cycle('0, hold_r, hold_l);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; acc_rght = 32'd0; acc_lft = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      vlog.delete();
      cyc = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (coef_addr !== '0) $display("FAIL reset_coef_addr: got %0h want 0", coef_addr); else passed++;
      checks++; if (band_sel !== 3'd0) $display("FAIL reset_band_sel: got %0h want 0", band_sel); else passed++;
      checks++; if (acc_clr !== 1'b0) $display("FAIL reset_acc_clr: got %b want 0", acc_clr); else passed++;
      checks++; if (acc_en !== 1'b0) $display("FAIL reset_acc_en: got %b want 0", acc_en); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if ({out_rght, out_lft, out_band} !== 35'd0) $display("FAIL reset_outs: got %h/%h/%h want 0", out_rght, out_lft, out_band); else passed++;
      checks++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b want 0", out_vld); else passed++;
      checks++; if (ovr !== '0) $display("FAIL reset_ovr: got %b want 0", ovr); else passed++;
   endtask

   task automatic test_latency();
      int r0;
      logic [AWB-1:0] ea;
      do_reset();
      repeat (3) cycle('0, 32'd0, 32'd0);
      r0 = cyc;
      cycle(5'b00001, 32'd0, 32'd0);
      for (int k = 1; k <= TP + 6; k++) begin
         ea = (k >= 3 && k <= TP + 2) ? AWB'(k - 3) : '0;
         checks++; if (acc_clr !== (k == 2)) $display("FAIL lat_acc_clr at r+%0d: got %b want %b", k, acc_clr, (k == 2)); else passed++;
         checks++; if (coef_addr !== ea) $display("FAIL lat_coef_addr at r+%0d: got %0d want %0d", k, coef_addr, ea); else passed++;
         checks++; if (acc_en !== (k >= 4 && k <= TP + 3)) $display("FAIL lat_acc_en at r+%0d: got %b", k, acc_en); else passed++;
         checks++; if (busy !== (k >= 2 && k <= TP + 4)) $display("FAIL lat_busy at r+%0d: got %b", k, busy); else passed++;
         checks++; if (out_vld !== (k == TP + 5)) $display("FAIL lat_out_vld at r+%0d: got %b", k, out_vld); else passed++;
         cycle('0, 32'd0, 32'd0);
      end
      checks++;
      if (vlog.size() != 1 || vlog[0].band != 0) $display("FAIL lat_result: got %0d results want 1 of band 0", vlog.size());
      else passed++;
   endtask

   task automatic test_simultaneous();
      int r0;
      do_reset();
      r0 = cyc;
      cycle(5'b10110, 32'd0, 32'd0);
      run_until(3, 60);
      checks++;
      if (vlog.size() != 3) $display("FAIL simul_count: got %0d want 3", vlog.size());
      else begin
         passed++;
         checks++; if (vlog[0].band != 1 || vlog[1].band != 2 || vlog[2].band != 4)
            $display("FAIL simul_order: got %0d,%0d,%0d want 1,2,4", vlog[0].band, vlog[1].band, vlog[2].band); else passed++;
         checks++; if (vlog[0].cyc != r0 + 5 + TP) $display("FAIL simul_first: got %0d want %0d", vlog[0].cyc, r0 + 5 + TP); else passed++;
         checks++; if (vlog[1].cyc - vlog[0].cyc != TP + 4 || vlog[2].cyc - vlog[1].cyc != TP + 4)
            $display("FAIL simul_spacing: got %0d,%0d want %0d", vlog[1].cyc - vlog[0].cyc, vlog[2].cyc - vlog[1].cyc, TP + 4); else passed++;
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      cycle(5'b01000, 32'd0, 32'd0);
      run_until(1, 20);
      cycle(5'b01001, 32'd0, 32'd0);
      run_until(3, 40);
      checks++;
      if (vlog.size() != 3) $display("FAIL rr_count: got %0d want 3", vlog.size());
      else begin
         passed++;
         checks++; if (vlog[0].band != 3 || vlog[1].band != 0 || vlog[2].band != 3)
            $display("FAIL rr_order: got %0d,%0d,%0d want 3,0,3", vlog[0].band, vlog[1].band, vlog[2].band); else passed++;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      hold_r = 32'h4000_0000; hold_l = 32'hB000_0000;
      cycle(5'b00001, hold_r, hold_l);
      run_until(1, 20);
      hold_r = 32'h0012_3456; hold_l = 32'hFFFF_8000;
      cycle(5'b00010, hold_r, hold_l);
      run_until(2, 20);
      checks++;
      if (vlog.size() != 2) $display("FAIL sat_count: got %0d want 2", vlog.size());
      else begin
         passed++;
         checks++; if (vlog[0].r !== 16'h7FFF) $display("FAIL sat_pos: got %h want 7fff", vlog[0].r); else passed++;
         checks++; if (vlog[0].l !== 16'h8000) $display("FAIL sat_neg: got %h want 8000", vlog[0].l); else passed++;
         checks++; if (vlog[1].r !== 16'h0024) $display("FAIL sat_inrange: got %h want 0024", vlog[1].r); else passed++;
         checks++; if (vlog[1].l !== 16'hFFFF) $display("FAIL sat_inrange_neg: got %h want ffff", vlog[1].l); else passed++;
         checks++; if (vlog[1].band != 1) $display("FAIL sat_band: got %0d want 1", vlog[1].band); else passed++;
      end
      hold_r = 32'd0; hold_l = 32'd0;
   endtask

   task automatic test_overrun();
      int i;
      do_reset();
      cycle(5'b00001, 32'd0, 32'd0);
      cycle(5'b00100, 32'd0, 32'd0);
      cycle('0, 32'd0, 32'd0);
      cycle(5'b00100, 32'd0, 32'd0);
      checks++; if (ovr !== 5'b00100) $display("FAIL ovr_set: got %b want 00100", ovr); else passed++;
      run_until(3, 40);
      checks++;
      if (vlog.size() != 2 || vlog[0].band != 0 || vlog[1].band != 2)
         $display("FAIL ovr_results: got %0d results want bands 0,2", vlog.size());
      else passed++;
      // Second request lands exactly on the band-2 grant cycle.
      do_reset();
      cycle(5'b00001, 32'd0, 32'd0);
      cycle(5'b00100, 32'd0, 32'd0);
      i = 0;
      while (!out_vld && i < 30) begin cycle('0, 32'd0, 32'd0); i++; end
      cycle(5'b00100, 32'd0, 32'd0);
      run_until(4, 40);
      checks++; if (ovr !== '0) $display("FAIL ovr_coincident: got %b want 00000", ovr); else passed++;
      checks++;
      if (vlog.size() != 3 || vlog[0].band != 0 || vlog[1].band != 2 || vlog[2].band != 2)
         $display("FAIL ovr_two_runs: got %0d results want bands 0,2,2", vlog.size());
      else passed++;
   endtask

   task automatic test_reset_mid_run();
      int r0;
      do_reset();
      cycle(5'b00001, 32'd0, 32'd0);
      cycle(5'b00010, 32'd0, 32'd0);
      cycle('0, 32'd0, 32'd0);
      cycle('0, 32'd0, 32'd0);
      checks++; if (acc_en !== 1'b1 || coef_addr !== 10'd1) $display("FAIL midrun_pre: got en=%b addr=%0d want 1/1", acc_en, coef_addr); else passed++;
      rst = 1'b1;
      #1;
      checks++; if (coef_addr !== '0 || acc_en !== 1'b0 || acc_clr !== 1'b0) $display("FAIL midrun_datapath: got addr=%0d en=%b clr=%b want 0", coef_addr, acc_en, acc_clr); else passed++;
      checks++; if (busy !== 1'b0 || band_sel !== 3'd0 || out_vld !== 1'b0) $display("FAIL midrun_ctrl: got busy=%b sel=%0d vld=%b want 0", busy, band_sel, out_vld); else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      vlog.delete();
      cyc = 0;
      r0 = cyc;
      cycle(5'b10000, 32'd0, 32'd0);
      run_until(2, 30);
      checks++;
      if (vlog.size() != 1 || vlog[0].band != 4 || vlog[0].cyc != r0 + 5 + TP)
         $display("FAIL midrun_after: got %0d results want one band-4 result at r+%0d", vlog.size(), 5 + TP);
      else passed++;
   endtask

   task automatic test_random();
      logic [NB-1:0]  r;
      logic [31:0]    ar, al;
      logic [AWB-1:0] ea;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         r = '0;
         for (int b = 0; b < NB; b++) if ($urandom_range(0, 11) == 0) r[b] = 1'b1;
         ar = $urandom; al = $urandom;
         if ($urandom_range(0, 1) == 1) ar = 32'($signed(ar) >>> 2);
         if ($urandom_range(0, 1) == 1) al = 32'($signed(al) >>> 2);
         cycle(r, ar, al);
         ea = (m_active && m_d >= 2 && m_d <= TP + 1) ? AWB'(m_d - 2) : '0;
         checks++; if (coef_addr !== ea) $display("FAIL rnd_coef_addr cyc %0d: got %0d want %0d", cyc, coef_addr, ea); else passed++;
         checks++; if (acc_clr !== (m_active && m_d == 1)) $display("FAIL rnd_acc_clr cyc %0d: got %b", cyc, acc_clr); else passed++;
         checks++; if (acc_en !== (m_active && m_d >= 3 && m_d <= TP + 2)) $display("FAIL rnd_acc_en cyc %0d: got %b", cyc, acc_en); else passed++;
         checks++; if (busy !== m_active) $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy, m_active); else passed++;
         checks++; if (band_sel !== 3'(m_band)) $display("FAIL rnd_band_sel cyc %0d: got %0d want %0d", cyc, band_sel, m_band); else passed++;
         checks++; if (out_vld !== m_vld) $display("FAIL rnd_out_vld cyc %0d: got %b want %b", cyc, out_vld, m_vld); else passed++;
         checks++; if (ovr !== m_ovr) $display("FAIL rnd_ovr cyc %0d: got %b want %b", cyc, ovr, m_ovr); else passed++;
         checks++;
         if (out_band !== 3'(m_ob) || out_rght !== m_or || out_lft !== m_ol)
            $display("FAIL rnd_result cyc %0d: got %0d/%h/%h want %0d/%h/%h", cyc, out_band, out_rght, out_lft, m_ob, m_or, m_ol);
         else passed++;
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; acc_rght = 32'd0; acc_lft = 32'd0;
      test_reset();
      test_latency();
      test_simultaneous();
      test_round_robin();
      test_saturation();
      test_overrun();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
